// File: rtl/eth_rx_frame_check_pkg.sv
// Shared Ethernet receive constants, FSM state type and the CRC-32 dibit step
// used by the RMII frame checker.
package eth_rx_frame_check_pkg;

  localparam int ETH_CRC_LEN       = 4;
  localparam int ETH_MIN_FRAME_LEN = 64;
  localparam int ETH_MAX_FRAME_LEN = 1518;
  localparam int ETH_DELAY_DEPTH   = ETH_CRC_LEN * 4;

  localparam logic [31:0] ETH_CRC_POLY    = 32'hedb88320;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hdebb20e3;

  localparam logic [1:0] DIBIT_IDLE = 2'b00;
  localparam logic [1:0] DIBIT_PRE  = 2'b01;
  localparam logic [1:0] DIBIT_SFD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_BODY,
    ST_DROP
  } rx_state_e;

  // Reflected CRC-32 advanced by one dibit, bit 0 first (RMII is LSB-first).
  function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] dibit);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      c = (c >> 1) ^ (((c[0] ^ dibit[i]) != 1'b0) ? ETH_CRC_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_rx_frame_check_crc32.sv
// Two-bit-per-cycle CRC-32 accumulator; out is the complemented register, so a
// frame with a correct FCS leaves out == ~ETH_CRC_RESIDUE.
module crc32
  import eth_rx_frame_check_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inclk,
  input  logic [1:0]  in,
  input  logic        shift,
  output logic [31:0] out
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (inclk) begin
      // Shift mode streams the complemented CRC out two bits at a time.
      crc_d = shift ? {2'b11, crc_q[31:2]} : crc32_dibit(crc_q, in);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 32'hffffffff;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign out = ~crc_q;

endmodule

// File: rtl/eth_rx_frame_check.sv
// RMII receive framer: finds preamble/SFD, forwards the body minus FCS through a
// 16-dibit delay line and reports a per-frame CRC/length verdict.
module eth_rx_frame_check
  import eth_rx_frame_check_pkg::*;
#(
  parameter int MIN_PREAMBLE_DIBITS = 8,
  parameter int MIN_FRAME_BYTES     = ETH_MIN_FRAME_LEN,
  parameter int MAX_FRAME_BYTES     = ETH_MAX_FRAME_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inclk,
  input  logic [1:0] in,
  output logic       outclk,
  output logic [1:0] out,
  output logic       done,
  output logic       crc_ok,
  output logic       err
);

  localparam int PCNT_W = $clog2(MIN_PREAMBLE_DIBITS + 1);
  localparam int FILL_W = $clog2(ETH_DELAY_DEPTH + 1);
  localparam int CNT_W  = 13;

  localparam logic [PCNT_W-1:0] PCNT_MAX    = PCNT_W'(MIN_PREAMBLE_DIBITS);
  localparam logic [FILL_W-1:0] FILL_FULL   = FILL_W'(ETH_DELAY_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_SAT     = CNT_W'(MAX_FRAME_BYTES * 4 + 1);
  localparam logic [CNT_W-1:0]  MIN_DIBITS  = CNT_W'(MIN_FRAME_BYTES * 4);
  localparam logic [CNT_W-1:0]  MAX_DIBITS  = CNT_W'(MAX_FRAME_BYTES * 4);

  rx_state_e state_q, state_d;

  logic [PCNT_W-1:0]                pcnt_q, pcnt_d;
  logic [ETH_DELAY_DEPTH-1:0][1:0]  dline_q, dline_d;
  logic [FILL_W-1:0]                fill_q, fill_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [1:0]                       out_q, out_d;
  logic                             outclk_q, outclk_d;
  logic                             done_q, done_d;
  logic                             crc_ok_q, crc_ok_d;
  logic                             err_q, err_d;

  logic        sfd_det;
  logic        body_push;
  logic        frame_end;
  logic [31:0] crc_out;

  assign body_push = (state_q == ST_BODY) && inclk;
  assign frame_end = (state_q == ST_BODY) && !inclk;

  crc32 u_crc32 (
    .clk   (clk),
    .rst   (rst || sfd_det),
    .inclk (body_push),
    .in    (in),
    .shift (1'b0),
    .out   (crc_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sfd_det = 1'b0;
    if (!inclk) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in == DIBIT_PRE) begin
            state_d = ST_PREAMBLE;
          end else if (in != DIBIT_IDLE) begin
            state_d = ST_DROP;
          end
        end
        ST_PREAMBLE: begin
          if (in == DIBIT_SFD && pcnt_q >= PCNT_MAX) begin
            state_d = ST_BODY;
            sfd_det = 1'b1;
          end else if (in != DIBIT_PRE) begin
            state_d = ST_DROP;
          end
        end
        ST_BODY: state_d = ST_BODY;
        ST_DROP: state_d = ST_DROP;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pcnt_d   = pcnt_q;
    dline_d  = dline_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    outclk_d = 1'b0;
    done_d   = 1'b0;
    crc_ok_d = 1'b0;
    err_d    = 1'b0;

    if (state_q == ST_IDLE && inclk && in == DIBIT_PRE) begin
      pcnt_d = PCNT_W'(1);
    end
    if (state_q == ST_PREAMBLE && inclk && in == DIBIT_PRE && pcnt_q != PCNT_MAX) begin
      pcnt_d = pcnt_q + 1'b1;
    end

    if (sfd_det) begin
      dline_d = '0;
      fill_d  = '0;
      cnt_d   = '0;
    end

    // Newest dibit enters at index 0; index DEPTH-1 is the oldest, evicted once full.
    if (body_push) begin
      dline_d = {dline_q[ETH_DELAY_DEPTH-2:0], in};
      if (fill_q == FILL_FULL) begin
        out_d    = dline_q[ETH_DELAY_DEPTH-1];
        outclk_d = 1'b1;
      end else begin
        fill_d = fill_q + 1'b1;
      end
      if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (frame_end) begin
      done_d   = 1'b1;
      crc_ok_d = (crc_out == ~ETH_CRC_RESIDUE);
      err_d    = !crc_ok_d || (cnt_q[1:0] != 2'b00) ||
                 (cnt_q < MIN_DIBITS) || (cnt_q > MAX_DIBITS);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q   <= '0;
      dline_q  <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      out_q    <= 2'b00;
      outclk_q <= 1'b0;
      done_q   <= 1'b0;
      crc_ok_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      dline_q  <= dline_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      outclk_q <= outclk_d;
      done_q   <= done_d;
      crc_ok_q <= crc_ok_d;
      err_q    <= err_d;
    end
  end

  assign outclk = outclk_q;
  assign out    = out_q;
  assign done   = done_q;
  assign crc_ok = crc_ok_q;
  assign err    = err_q;

endmodule

// File: tb/tb_eth_rx_frame_check.sv
// Self-checking bench: random frames are driven dibit by dibit and the DUT's
// forwarded dibits and verdicts are compared against a frame-level model.
module tb_eth_rx_frame_check;

  localparam int MIN_PRE = 8;
  localparam int MIN_B   = 64;
  localparam int MAX_B   = 1518;

  typedef struct {
    logic [1:0] d;
    int         c;
  } dibit_t;

  typedef struct {
    int   c;
    logic ok;
    logic err;
  } verdict_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       inclk;
  logic [1:0] dut_in;
  logic       outclk;
  logic [1:0] dut_out;
  logic       done;
  logic       crc_ok;
  logic       err;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  dibit_t   burst[$];
  dibit_t   exp_out[$];
  dibit_t   got_out[$];
  verdict_t exp_done[$];
  verdict_t got_done[$];
  logic [7:0] fb[$];

  eth_rx_frame_check #(
    .MIN_PREAMBLE_DIBITS (MIN_PRE),
    .MIN_FRAME_BYTES     (MIN_B),
    .MAX_FRAME_BYTES     (MAX_B)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .inclk  (inclk),
    .in     (dut_in),
    .outclk (outclk),
    .out    (dut_out),
    .done   (done),
    .crc_ok (crc_ok),
    .err    (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are registered at the rising edge, so collect them mid-cycle.
  always @(negedge clk) begin
    if (outclk === 1'b1) begin
      dibit_t o;
      o.d = dut_out;
      o.c = cyc;
      got_out.push_back(o);
    end
    if (done === 1'b1) begin
      verdict_t v;
      v.c   = cyc;
      v.ok  = crc_ok;
      v.err = err;
      got_done.push_back(v);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] crcBit(input logic [31:0] c, input logic b);
    return (c >> 1) ^ ((c[0] ^ b) ? 32'hedb88320 : 32'h0);
  endfunction

  // Frame-level reference: parse a whole inclk-high burst by the receive rules.
  task automatic modelBurst(input bit aborted, input int fall_cyc);
    int i, p, s, len, n;
    logic [31:0] c;
    verdict_t v;
    n = burst.size();
    i = 0;
    while (i < n && burst[i].d == 2'b00) i++;
    if (i >= n || burst[i].d != 2'b01) return;
    p = 0;
    while (i < n && burst[i].d == 2'b01) begin
      p++;
      i++;
    end
    if (i >= n || burst[i].d != 2'b11 || p < MIN_PRE) return;
    s = i + 1;
    len = n - s;
    for (int k = 0; k + 16 < len; k++) begin
      dibit_t o;
      o.d = burst[s + k].d;
      o.c = burst[s + k + 16].c + 1;
      exp_out.push_back(o);
    end
    if (aborted) return;
    c = 32'hffffffff;
    for (int k = s; k < n; k++) begin
      c = crcBit(c, burst[k].d[0]);
      c = crcBit(c, burst[k].d[1]);
    end
    v.c   = fall_cyc + 1;
    v.ok  = (c == 32'hdebb20e3);
    v.err = !v.ok || (len % 4 != 0) || (len / 4 < MIN_B) || (len / 4 > MAX_B);
    exp_done.push_back(v);
  endtask

  task automatic applyStimulus(input logic [1:0] d);
    dibit_t e;
    @(posedge clk);
    #1;
    inclk  = 1'b1;
    dut_in = d;
    e.d = d;
    e.c = cyc;
    burst.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      inclk  = 1'b0;
      dut_in = 2'($urandom);
      if (burst.size() != 0) begin
        modelBurst(1'b0, cyc);
        burst.delete();
      end
    end
  endtask

  task automatic resetPulse(input logic [1:0] d);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    inclk  = 1'b1;
    dut_in = d;
    modelBurst(1'b1, cyc);
    burst.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #0;
    // The dibit held across reset release is seen by the DUT in IDLE.
  endtask

  task automatic makeFrame(input int nbytes, input bit corrupt);
    logic [31:0] c;
    logic [7:0] b;
    int idx;
    fb.delete();
    c = 32'hffffffff;
    for (int k = 0; k < nbytes; k++) begin
      b = 8'($urandom);
      fb.push_back(b);
      for (int j = 0; j < 8; j++) c = crcBit(c, b[j]);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) fb.push_back(c[8*k +: 8]);
    if (corrupt) begin
      idx = $urandom_range(nbytes - 1, 0);
      fb[idx] = fb[idx] ^ (8'h01 << $urandom_range(7, 0));
    end
  endtask

  task automatic sendPreamble(input int n01);
    for (int k = 0; k < n01; k++) applyStimulus(2'b01);
    applyStimulus(2'b11);
  endtask

  task automatic sendBody(input int rst_at);
    int i;
    logic [7:0] b;
    i = 0;
    foreach (fb[k]) begin
      b = fb[k];
      for (int j = 0; j < 4; j++) begin
        if (i == rst_at) resetPulseInline(b[2*j +: 2]);
        else applyStimulus(b[2*j +: 2]);
        i++;
      end
    end
  endtask

  task automatic resetPulseInline(input logic [1:0] d);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    inclk  = 1'b1;
    dut_in = d;
    modelBurst(1'b1, cyc);
    burst.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Keep the input stable for the cycle just after release; it is part of the new burst.
    begin
      dibit_t e;
      e.d = d;
      e.c = cyc;
      burst.push_back(e);
    end
  endtask

  task automatic checkAll(input string name);
    int m;
    checkOutput({name, "_out_count"}, got_out.size(), exp_out.size());
    m = (got_out.size() < exp_out.size()) ? got_out.size() : exp_out.size();
    for (int k = 0; k < m; k++) begin
      checkOutput({name, "_out_dibit"}, 32'(got_out[k].d), 32'(exp_out[k].d));
      checkOutput({name, "_out_cycle"}, got_out[k].c, exp_out[k].c);
    end
    checkOutput({name, "_done_count"}, got_done.size(), exp_done.size());
    m = (got_done.size() < exp_done.size()) ? got_done.size() : exp_done.size();
    for (int k = 0; k < m; k++) begin
      checkOutput({name, "_done_cycle"}, got_done[k].c, exp_done[k].c);
      checkOutput({name, "_crc_ok"}, 32'(got_done[k].ok), 32'(exp_done[k].ok));
      checkOutput({name, "_err"}, 32'(got_done[k].err), 32'(exp_done[k].err));
    end
    got_out.delete();
    exp_out.delete();
    got_done.delete();
    exp_done.delete();
  endtask

  initial begin
    rst    = 1'b1;
    inclk  = 1'b0;
    dut_in = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outclk", 32'(outclk), 32'h0);
    checkOutput("reset_out", 32'(dut_out), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_crc_ok", 32'(crc_ok), 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);
    rst = 1'b0;
    idleCycles(2);

    // Good 60-byte body with 32-dibit preamble.
    makeFrame(60, 1'b0);
    sendPreamble(31);
    sendBody(-1);
    idleCycles(4);
    checkAll("good");

    // Same shape, body byte 20 bit 3 flipped after FCS computed.
    makeFrame(60, 1'b0);
    fb[20] = fb[20] ^ 8'h08;
    sendPreamble(31);
    sendBody(-1);
    idleCycles(4);
    checkAll("bitflip");

    makeFrame(20, 1'b0);
    sendPreamble(31);
    sendBody(-1);
    idleCycles(4);
    checkAll("runt");

    // Short preamble, then one idle cycle, then a good frame.
    makeFrame(60, 1'b0);
    sendPreamble(4);
    sendBody(-1);
    idleCycles(1);
    makeFrame(60, 1'b0);
    sendPreamble(31);
    sendBody(-1);
    idleCycles(4);
    checkAll("badpre");

    makeFrame(60, 1'b0);
    sendPreamble(31);
    sendBody(-1);
    applyStimulus(2'b00);
    applyStimulus(2'b00);
    idleCycles(4);
    checkAll("align");

    // Reset pulse at body dibit 100, remainder of the frame still driven.
    makeFrame(60, 1'b0);
    sendPreamble(31);
    sendBody(100);
    idleCycles(4);
    makeFrame(60, 1'b0);
    sendPreamble(31);
    sendBody(-1);
    idleCycles(4);
    checkAll("midreset");

    // Length boundaries and the minimum preamble.
    makeFrame(59, 1'b0);
    sendPreamble(MIN_PRE);
    sendBody(-1);
    idleCycles(4);
    makeFrame(60, 1'b0);
    sendPreamble(MIN_PRE - 1);
    sendBody(-1);
    idleCycles(4);
    makeFrame(1514, 1'b0);
    sendPreamble(MIN_PRE);
    sendBody(-1);
    idleCycles(4);
    makeFrame(1515, 1'b0);
    sendPreamble(MIN_PRE);
    sendBody(-1);
    idleCycles(4);
    checkAll("bounds");

    // Random back-to-back traffic with 1..3 idle cycles between frames.
    for (int f = 0; f < 24; f++) begin
      makeFrame($urandom_range(120, 8), ($urandom_range(3, 0) == 0));
      sendPreamble($urandom_range(20, MIN_PRE - 2));
      sendBody(-1);
      if ($urandom_range(3, 0) == 0) applyStimulus(2'($urandom));
      idleCycles($urandom_range(3, 1));
    end
    idleCycles(4);
    checkAll("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_rx_frame_check.md
Name: eth_rx_frame_check

Overview:
- Receive-side framer that sits between the RMII dibit input and eth_rx.
- Searches for the preamble and SFD on the raw dibit stream, then forwards the frame body (MAC dst through the last payload dibit) as dibits.
- Strips the 4-byte FCS using a 16-dibit delay line.
- Verifies the CRC-32 residue and frame length, then reports a per-frame done/crc_ok/err verdict.

Parameters:
- MIN_PREAMBLE_DIBITS, 8: minimum count of consecutive 2'b01 dibits before the SFD dibit 2'b11.
- MIN_FRAME_BYTES, 64: minimum frame length in bytes, including FCS.
- MAX_FRAME_BYTES, 1518: maximum frame length in bytes, including FCS.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock clk
- inclk  in  1  dibit valid (CRS_DV); a frame ends on the first cycle it is low
- in  in  2  received dibit, LSB-first
- outclk  out  1  body dibit valid; reset 0
- out  out  2  body dibit; reset 2'b00; holds its last value when outclk=0
- done  out  1  one-cycle end-of-frame pulse; reset 0
- crc_ok  out  1  CRC residue matched; valid when done=1; reset 0
- err  out  1  frame error; valid when done=1; reset 0

Behaviour:
- State machine: IDLE, PREAMBLE, BODY, DROP. Any cycle with inclk=0 returns the FSM to IDLE (BODY first takes the end-of-frame path below).
- IDLE, inclk=1:
  - in=01 -> PREAMBLE, pcnt=1.
  - in=00 -> stay in IDLE.
  - in=10 or 11 -> DROP.
- PREAMBLE, inclk=1:
  - in=01 -> pcnt++ (saturating).
  - in=11 with pcnt>=MIN_PREAMBLE_DIBITS -> BODY; clear the CRC, the delay line and the dibit counter.
  - in=11 with pcnt<MIN_PREAMBLE_DIBITS -> DROP.
  - in=00 or 10 -> DROP.
- DROP: ignore input until inclk=0. Never produces outclk or done.
- BODY, each accepted dibit:
  - Feed crc32 (initial 32'hffffffff, reflected polynomial 32'hedb88320, 2 bits per step).
  - Shift the dibit into the 16-entry delay line.
  - Increment the 13-bit dibit counter, saturating at MAX_FRAME_BYTES*4+1.
- Delay-line output:
  - Once the delay line holds 16 entries, each push evicts the oldest entry.
  - The evicted dibit is registered: outclk=1 and out=evicted dibit on the following cycle.
  - Body dibit k appears one cycle after input dibit k+16 is accepted.
  - No outclk while the delay line holds fewer than 16 entries.
- End of frame (BODY and inclk=0 at cycle T):
  - At cycle T+1: done=1.
  - crc_ok=1 iff the internal CRC register equals ETH_CRC_RESIDUE (32'hdebb20e3, i.e. crc32 out == 32'h2144df1c).
  - err=1 if any of: !crc_ok; dibit count not a multiple of 4; byte count < MIN_FRAME_BYTES; byte count > MAX_FRAME_BYTES.
  - done, crc_ok and err return to 0 at T+2.
  - The last outclk always precedes done by at least one cycle.
  - Frame with fewer than 16 body dibits: no outclk; done with err=1.
- Back-to-back frames: one idle cycle (inclk=0) separates frames. A new preamble may start at T+1 while done is asserted.
- rst mid-frame: all state and outputs cleared; no done for the aborted frame. If inclk is still high after reset release, the IDLE rules apply and the remainder of the frame falls into DROP or is ignored.

Decomposition:
- Add to networking.vh: ETH_CRC_RESIDUE, ETH_MIN_FRAME_LEN (64) and ETH_MAX_FRAME_LEN (1518). Reuse the existing ETH_CRC_LEN (4) and derive the delay depth as ETH_CRC_LEN*4.
- Instantiate the existing crc32 module:
  - rst driven by rst || SFD detect.
  - inclk driven by BODY && inclk.
  - shift tied to 0.
- The delay line and FSM stay inline.

Test Plan:
- Good frame: 32 preamble dibits (31x 01 then 11), 60-byte body, correct FCS -> 240 outclk pulses matching body dibits in order; done=1, crc_ok=1, err=0 one cycle after inclk falls.
- Same frame with body byte 20 bit 3 flipped -> 240 outclk pulses; done=1, crc_ok=0, err=1.
- Runt: 20-byte body plus correct FCS -> 80 outclk pulses; done=1, crc_ok=1, err=1.
- Bad preamble: 4x 01 then 11, followed by a 60-byte body -> no outclk, no done; a following good frame after one idle cycle is fully accepted.
- Alignment: good 64-byte frame plus 2 extra dibits 00 00 -> done=1, err=1.
- Reset: rst for one cycle at body dibit 100, rest of frame driven -> no outclk after reset and no done. Next good frame -> crc_ok=1, err=0.
